// File: rtl/iir_mac_scheduler.sv
// iir_mac_scheduler: multi-channel first-order IIR filter bank that time-shares one signed multiplier
module iir_mac_scheduler #(
  parameter int COEFF_WIDTH = 18,
  parameter int COEFF_SCALE = 15,
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_BITS  = 10,
  parameter int CHANNELS    = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [COUNT_BITS-1:0]          div,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [2:0]                     cfg_ch,
  input  logic [1:0]                     cfg_sel,
  input  logic [COEFF_WIDTH-1:0]         cfg_data,
  output logic [CHANNELS*DATA_WIDTH-1:0] out,
  output logic                           out_valid,
  output logic                           busy,
  output logic                           overrun
);
  localparam int ACCW = DATA_WIDTH + COEFF_WIDTH + 2;
  localparam int CHB = $clog2(CHANNELS);
  localparam logic signed [COEFF_WIDTH-1:0] ONE = COEFF_WIDTH'(2 ** COEFF_SCALE);
  localparam logic signed [ACCW-1:0] MAXV = ACCW'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [ACCW-1:0] MINV = ~MAXV;
  typedef enum logic [2:0] {IDLE, MUL_B1, MUL_B2, MUL_A2, WRITE} state_t;
  state_t state_q, state_d;
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic [CHB-1:0] ch_q, ch_d, cfg_idx;
  logic signed [ACCW-1:0] acc_q, acc_d, prod, shifted;
  logic signed [COEFF_WIDTH-1:0] b1_q [CHANNELS], b1_d [CHANNELS];
  logic signed [COEFF_WIDTH-1:0] b2_q [CHANNELS], b2_d [CHANNELS];
  logic signed [COEFF_WIDTH-1:0] a2_q [CHANNELS], a2_d [CHANNELS];
  logic signed [DATA_WIDTH-1:0] x0_q [CHANNELS], x0_d [CHANNELS];
  logic signed [DATA_WIDTH-1:0] x1_q [CHANNELS], x1_d [CHANNELS];
  logic signed [DATA_WIDTH-1:0] y0_q [CHANNELS], y0_d [CHANNELS];
  logic signed [COEFF_WIDTH-1:0] coeff;
  logic signed [DATA_WIDTH-1:0] data, sat;
  logic out_valid_q, out_valid_d, overrun_q, overrun_d, tick, cfg_we;
  assign busy = state_q != IDLE;
  assign cfg_ready = ~busy;
  assign out_valid = out_valid_q;
  assign overrun = overrun_q;
  assign tick = count_q == div - COUNT_BITS'(1);
  assign cfg_we = cfg_valid && cfg_ready && 4'(cfg_ch) < 4'(CHANNELS) && cfg_sel != 2'd3;
  assign cfg_idx = cfg_ch[CHB-1:0];
  assign coeff = state_q == MUL_B1 ? b1_q[ch_q] : state_q == MUL_B2 ? b2_q[ch_q] : a2_q[ch_q];
  assign data = state_q == MUL_B1 ? x0_q[ch_q] : state_q == MUL_B2 ? x1_q[ch_q] : y0_q[ch_q];
  assign prod = ACCW'(coeff) * ACCW'(data);
  assign shifted = acc_q >>> COEFF_SCALE;
  assign sat = shifted > MAXV ? MAXV[DATA_WIDTH-1:0] :
               shifted < MINV ? MINV[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
  for (genvar i = 0; i < CHANNELS; i++) begin : g_out
    assign out[i*DATA_WIDTH +: DATA_WIDTH] = y0_q[i];
  end
  always_comb begin
    state_d = state_q;
    count_d = tick ? '0 : count_q + COUNT_BITS'(1);
    ch_d = ch_q;
    acc_d = acc_q;
    b1_d = b1_q;
    b2_d = b2_q;
    a2_d = a2_q;
    x0_d = x0_q;
    x1_d = x1_q;
    y0_d = y0_q;
    out_valid_d = 1'b0;
    overrun_d = overrun_q | (tick & busy);
    if (cfg_we) begin
      if (cfg_sel == 2'd0) b1_d[cfg_idx] = cfg_data;
      if (cfg_sel == 2'd1) b2_d[cfg_idx] = cfg_data;
      if (cfg_sel == 2'd2) a2_d[cfg_idx] = cfg_data;
    end
    case (state_q)
      IDLE: if (tick) begin
        state_d = MUL_B1;
        ch_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
          x1_d[k] = x0_q[k];
          x0_d[k] = in[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      MUL_B1: begin
        acc_d = prod;
        state_d = MUL_B2;
      end
      MUL_B2: begin
        acc_d = acc_q + prod;
        state_d = MUL_A2;
      end
      MUL_A2: begin
        acc_d = acc_q - prod;
        state_d = WRITE;
      end
      WRITE: begin
        y0_d[ch_q] = sat;
        out_valid_d = ch_q == CHB'(CHANNELS - 1);
        state_d = out_valid_d ? IDLE : MUL_B1;
        ch_d = out_valid_d ? ch_q : ch_q + CHB'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      ch_q <= '0;
      acc_q <= '0;
      b1_q <= '{default: ONE};
      b2_q <= '{default: '0};
      a2_q <= '{default: '0};
      x0_q <= '{default: '0};
      x1_q <= '{default: '0};
      y0_q <= '{default: '0};
      out_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ch_q <= ch_d;
      acc_q <= acc_d;
      b1_q <= b1_d;
      b2_q <= b2_d;
      a2_q <= a2_d;
      x0_q <= x0_d;
      x1_q <= x1_d;
      y0_q <= y0_d;
      out_valid_q <= out_valid_d;
      overrun_q <= overrun_d;
    end
  end
endmodule
